// File: rtl/etapa_fetch_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and the IF/ID register outputs.
// master = the fetch stage, slave = memory, hazard unit and decode side.
interface etapa_fetch_if;
   logic [31:0] Address;
   logic [31:0] Instruction;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectTarget;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic        MisalignedErr;
   logic [15:0] FetchCount;

   modport master (
      output Address,
      input  Instruction,
      input  Stall,
      input  Redirect,
      input  RedirectTarget,
      output IF_ID_Instruction,
      output IF_ID_PCPlus4,
      output IF_ID_Valid,
      output MisalignedErr,
      output FetchCount
   );

   modport slave (
      input  Address,
      output Instruction,
      output Stall,
      output Redirect,
      output RedirectTarget,
      input  IF_ID_Instruction,
      input  IF_ID_PCPlus4,
      input  IF_ID_Valid,
      input  MisalignedErr,
      input  FetchCount
   );
endinterface

// File: rtl/etapa_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, sticky misaligned-redirect flag
// and an accepted-instruction counter. Priority per edge is redirect, then stall, then advance.
module etapa_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst_n,
   etapa_fetch_if.master bus
);
   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;

   // Low two PC bits are forced to zero so the PC is word aligned even if RESET_PC is not.
   localparam logic [XLEN-1:0] RESET_PC_AL = {RESET_PC[XLEN-1:2], 2'b00};
   localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);

   logic [XLEN-1:0]  pc_q,    pc_d;
   logic [XLEN-1:0]  instr_q, instr_d;
   logic [XLEN-1:0]  pcp4_q,  pcp4_d;
   logic             valid_q, valid_d;
   logic             err_q,   err_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [XLEN-1:0]  pc_plus4;

   assign pc_plus4 = pc_q + PC_STEP;

   // Next-state selection
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      pcp4_d  = pcp4_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (bus.Redirect) begin
         pc_d    = {bus.RedirectTarget[XLEN-1:2], 2'b00};
         instr_d = NOP_WORD;
         pcp4_d  = '0;
         valid_d = 1'b0;
         err_d   = err_q | (bus.RedirectTarget[1:0] != 2'b00);
      end else if (!bus.Stall) begin
         pc_d    = pc_plus4;
         instr_d = bus.Instruction;
         pcp4_d  = pc_plus4;
         valid_d = 1'b1;
         cnt_d   = cnt_q + CNT_W'(1);
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC_AL;
         instr_q <= NOP_WORD;
         pcp4_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pcp4_q  <= pcp4_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Address           = pc_q;
   assign bus.IF_ID_Instruction = instr_q;
   assign bus.IF_ID_PCPlus4     = pcp4_q;
   assign bus.IF_ID_Valid       = valid_q;
   assign bus.MisalignedErr     = err_q;
   assign bus.FetchCount        = cnt_q;
endmodule

// File: tb/tb_etapa_fetch.sv
// Self-checking bench for etapa_fetch: directed scenarios followed by random stall/redirect traffic,
// compared against a behavioural model of the fetch stage.
module tb_etapa_fetch;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   etapa_fetch_if bus ();

   etapa_fetch #(.RESET_PC(32'h0000_0000), .NOP_WORD(NOP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h2008_0001;
         32'h0000_0004: return 32'h2009_0002;
         32'h0000_0008: return 32'h0109_5020;
         default:       return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
      endcase
   endfunction

   assign bus.Instruction = mem_word(bus.Address);

   // Reference model state
   logic [31:0] m_pc, m_instr, m_pcp4;
   logic        m_valid, m_err;
   logic [15:0] m_cnt;

   task automatic model_reset();
      m_pc = 32'h0; m_instr = NOP; m_pcp4 = 32'h0; m_valid = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
   endtask

   task automatic model_step(input logic stall, input logic redir, input logic [31:0] tgt);
      if (redir) begin
         if (tgt % 4 != 0) m_err = 1'b1;
         m_pc    = tgt - (tgt % 4);
         m_instr = NOP;
         m_pcp4  = 32'h0;
         m_valid = 1'b0;
      end else if (!stall) begin
         m_instr = mem_word(m_pc);
         m_pc    = m_pc + 32'd4;
         m_pcp4  = m_pc;
         m_valid = 1'b1;
         m_cnt   = m_cnt + 16'd1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".addr"},  bus.Address, m_pc);
      check({tag, ".instr"}, bus.IF_ID_Instruction, m_instr);
      check({tag, ".pcp4"},  bus.IF_ID_PCPlus4, m_pcp4);
      check({tag, ".valid"}, 32'(bus.IF_ID_Valid), 32'(m_valid));
      check({tag, ".err"},   32'(bus.MisalignedErr), 32'(m_err));
      check({tag, ".cnt"},   32'(bus.FetchCount), 32'(m_cnt));
   endtask

   // Drive inputs, apply one rising edge, then compare everything one step after the edge.
   task automatic cycle(input string tag, input logic stall, input logic redir, input logic [31:0] tgt);
      bus.Stall = stall;
      bus.Redirect = redir;
      bus.RedirectTarget = tgt;
      model_step(stall, redir, tgt);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      bus.Stall = 1'b0;
      bus.Redirect = 1'b0;
      bus.RedirectTarget = 32'h0;

      // Asynchronous reset before any clock edge
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset_async");
      @(posedge clk);
      #1;
      check_all("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      model_step(1'b0, 1'b0, 32'h0);
      #1;
      check_all("first_fetch");
      check("first_word", bus.IF_ID_Instruction, 32'h2008_0001);

      cycle("fetch2", 1'b0, 1'b0, 32'h0);
      check("second_pcp4", bus.IF_ID_PCPlus4, 32'h8);
      check("addr_before_stall", bus.Address, 32'h8);
      cycle("stall1", 1'b1, 1'b0, 32'h0);
      cycle("stall2", 1'b1, 1'b0, 32'h0);
      check("stall_addr", bus.Address, 32'h8);
      cycle("fetch3", 1'b0, 1'b0, 32'h0);
      check("third_word", bus.IF_ID_Instruction, 32'h0109_5020);
      check("third_pcp4", bus.IF_ID_PCPlus4, 32'hC);
      check("count3", 32'(bus.FetchCount), 32'd3);

      cycle("fetch4", 1'b0, 1'b0, 32'h0);
      check("at_0x10", bus.Address, 32'h10);
      cycle("redir_stall", 1'b1, 1'b1, 32'h40);
      check("redir_addr", bus.Address, 32'h40);
      check("redir_nop", bus.IF_ID_Instruction, NOP);
      cycle("after_redir", 1'b0, 1'b0, 32'h0);
      check("after_redir_pcp4", bus.IF_ID_PCPlus4, 32'h44);

      cycle("misaligned", 1'b0, 1'b1, 32'h43);
      check("mis_addr", bus.Address, 32'h40);
      check("mis_err", 32'(bus.MisalignedErr), 32'd1);
      cycle("aligned_after", 1'b0, 1'b1, 32'h80);
      cycle("free_after", 1'b0, 1'b0, 32'h0);
      check("err_sticky", 32'(bus.MisalignedErr), 32'd1);
      cycle("redir_self", 1'b0, 1'b1, bus.Address);

      cycle("redir_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
      cycle("wrap", 1'b0, 1'b0, 32'h0);
      check("wrap_pcp4", bus.IF_ID_PCPlus4, 32'h0);
      check("wrap_addr", bus.Address, 32'h0);

      // Random stall/redirect traffic
      for (int i = 0; i < 300; i++) begin
         logic s, r;
         logic [31:0] t;
         s = ($urandom_range(0, 3) == 0);
         r = ($urandom_range(0, 7) == 0);
         t = $urandom;
         cycle("rand", s, r, t);
      end

      // Reset pulse between edges while stalled at 0x24
      cycle("to_0x24", 1'b1, 1'b1, 32'h24);
      cycle("stall_0x24", 1'b1, 1'b0, 32'h0);
      check("pc_0x24", bus.Address, 32'h24);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("reset_pulse");
      #1 rst_n = 1'b1;
      cycle("post_reset", 1'b0, 1'b0, 32'h0);
      check("post_reset_word", bus.IF_ID_Instruction, 32'h2008_0001);
      check("post_reset_pcp4", bus.IF_ID_PCPlus4, 32'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/etapa_fetch.md
ETAPA_FETCH -- requirements
Module: etapa_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, PC value loaded on reset; bits [1:0] SHALL be 00.
REQ-002 Parameter NOP_WORD, default 32'h00000000, word inserted into IF/ID on flush or reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Address  output  32  current PC, driven to instruction memory.
REQ-006 Instruction  input  32  word returned combinationally by instruction memory for Address.
REQ-007 Stall  input  1  hazard unit hold request; freeze PC and IF/ID.
REQ-008 Redirect  input  1  taken branch or jump from a later stage.
REQ-009 RedirectTarget  input  32  next PC when Redirect=1.
REQ-010 IF_ID_Instruction  output  32  registered fetched instruction.
REQ-011 IF_ID_PCPlus4  output  32  registered PC+4 of that instruction.
REQ-012 IF_ID_Valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble.
REQ-013 MisalignedErr  output  1  sticky flag: a redirect target had bits [1:0] != 00.
REQ-014 FetchCount  output  16  number of instructions accepted into IF/ID since reset.

Function
REQ-015 Address SHALL equal the PC register at all times; no combinational path from Stall/Redirect to Address.
REQ-016 PC update priority each edge: Redirect > Stall > normal; evaluated only when rst_n=1.
REQ-017 Normal (Redirect=0, Stall=0): PC <= PC+4; IF/ID <= {Instruction, PC+4}; IF_ID_Valid <= 1; FetchCount += 1.
REQ-018 Stall=1, Redirect=0: PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, FetchCount all hold.
REQ-019 Redirect=1 (Stall ignored): PC <= {RedirectTarget[31:2], 2'b00}; IF_ID_Instruction <= NOP_WORD; IF_ID_PCPlus4 <= 0; IF_ID_Valid <= 0; FetchCount holds.
REQ-020 Redirect=1 with RedirectTarget[1:0] != 00: MisalignedErr <= 1 in the same edge; remains 1 until reset.
REQ-021 PC arithmetic: 32-bit unsigned modulo 2^32; 32'hFFFFFFFC + 4 wraps to 32'h00000000 with no flag.
REQ-022 FetchCount: 16-bit modulo; 16'hFFFF + 1 wraps to 0 with no flag.
REQ-023 Latency: instruction at Address in cycle N appears on IF_ID_* after edge N (one cycle).
REQ-024 PC[1:0] SHALL always read 00.
REQ-025 Redirect to the current PC value: treated as a normal redirect (flush + reload), no special case.

Reset
REQ-026 rst_n=0 immediately (without clock): PC = RESET_PC, IF_ID_Instruction = NOP_WORD, IF_ID_PCPlus4 = 0, IF_ID_Valid = 0, MisalignedErr = 0, FetchCount = 0.
REQ-027 Reset asserted mid-operation (any Stall/Redirect state) SHALL override all inputs; first fetch after deassertion is from RESET_PC.
REQ-028 Deassertion: first rising edge with rst_n=1 performs a normal REQ-016 update.

Verification
REQ-029 Reset then 3 free cycles, memory words 0x20080001, 0x20090002, 0x01095020 at 0x0/0x4/0x8 -> IF_ID shows them in order with PCPlus4 = 4, 8, 0xC; Valid = 1; FetchCount = 3.
REQ-030 Stall held 2 cycles at PC=0x8 -> Address stays 0x8; IF_ID and FetchCount unchanged; after release, next edge loads word at 0x8.
REQ-031 Redirect=1, Stall=1, RedirectTarget=0x40 at PC=0x10 -> next Address = 0x40, IF_ID_Valid = 0, IF_ID_Instruction = NOP_WORD; following edge loads word at 0x40 with PCPlus4 = 0x44.
REQ-032 RedirectTarget=0x43 -> Address = 0x40, MisalignedErr = 1 and stays 1 across later redirects to aligned targets until rst_n=0.
REQ-033 Redirect to 0xFFFFFFFC then one free cycle -> IF_ID_PCPlus4 = 0x00000000, Address = 0x00000000.
REQ-034 rst_n pulsed low between clock edges during a stall at PC=0x24 -> outputs take reset values immediately; Address = RESET_PC before the next edge.
